sha1_wb_master: RTL and testbench

- Wishbone initiator that drives the SHA1 Wishbone peripheral end to end.
- Sequence:
  - verify the peripheral ID;
  - switch the engine on, which clears its indices;
  - write the 16 message words;
  - poll the OPS register for DONE;
  - read the 5 digest words back.
- Sits between a local controller (a single start pulse plus a 512-bit block) and the Caravel-side Wishbone bus.

---
 rtl/sha1_wb_master.sv | 210 +++++++++++++++++++++
 tb/tb_sha1_wb_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_wb_master.sv
// Wishbone initiator for the SHA1 peripheral. It checks the peripheral ID,
// enables the engine, loads one 512-bit block, polls for DONE, and reads
// back the 160-bit digest. Every transfer is single-beat. The strobe is held
// for exactly one cycle, and there is at least one idle cycle between
// transfers.
module sha1_wb_master #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned POLL_MAX     = 1024
) (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] msg_i,
    output logic         busy,
    output logic [159:0] digest_o,
    output logic         digest_valid,
    output logic [1:0]   error,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic         wbm_ack_i,
    input  logic [31:0]  wbm_dat_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_WR_ON  = 3'd2;
    localparam logic [2:0] S_WR_MSG = 3'd3;
    localparam logic [2:0] S_POLL   = 3'd4;
    localparam logic [2:0] S_RD_DIG = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    localparam logic [31:0] ADR_ID     = BASE_ADDRESS + 32'h4;
    localparam logic [31:0] ADR_MSG    = BASE_ADDRESS + 32'h8;
    localparam logic [31:0] ADR_OPS    = BASE_ADDRESS + 32'hC;
    localparam logic [31:0] ADR_DIGEST = BASE_ADDRESS + 32'h14;
    localparam logic [31:0] SHA1_ID    = 32'h53484131;

    localparam logic [7:0]  L_TMO  = ACK_TIMEOUT[7:0];
    localparam logic [15:0] L_POLL = POLL_MAX[15:0];

    logic [2:0]   r_state;
    logic         r_cyc;
    logic         r_stb;
    logic         r_we;
    logic [3:0]   r_sel;
    logic [31:0]  r_adr;
    logic [31:0]  r_dat;
    logic [7:0]   r_tmo;
    logic [3:0]   r_word;
    logic [2:0]   r_dig;
    logic [15:0]  r_poll;
    logic [511:0] r_msg;
    logic [159:0] r_digest;
    logic         r_valid;
    logic [1:0]   r_error;
    logic         r_busy;

    logic         w_we;
    logic [31:0]  w_adr;
    logic [31:0]  w_dat;
    logic [15:0]  w_poll_next;

    assign w_poll_next = r_poll + 16'd1;

    // Select the address, direction and data for the transfer the current state issues.
    always_comb begin
        w_we  = 1'b0;
        w_adr = 32'h0;
        w_dat = 32'h0;
        case (r_state)
            S_RD_ID:  w_adr = ADR_ID;
            S_WR_ON: begin
                w_we  = 1'b1;
                w_adr = ADR_OPS;
                w_dat = 32'h1;
            end
            S_WR_MSG: begin
                w_we  = 1'b1;
                w_adr = ADR_MSG;
                w_dat = r_msg[{r_word, 5'b0} +: 32];
            end
            S_POLL:   w_adr = ADR_OPS;
            S_RD_DIG: w_adr = ADR_DIGEST;
            default:  w_adr = 32'h0;
        endcase
    end

    // Sequence control together with the single-beat bus engine.
    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= 4'h0;
            r_adr    <= 32'h0;
            r_dat    <= 32'h0;
            r_tmo    <= 8'h0;
            r_word   <= 4'h0;
            r_dig    <= 3'h0;
            r_poll   <= 16'h0;
            r_msg    <= 512'h0;
            r_digest <= 160'h0;
            r_valid  <= 1'b0;
            r_error  <= 2'd0;
            r_busy   <= 1'b0;
        end else begin
            // The strobe is only ever high in the cycle in which a transfer is issued.
            r_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msg   <= msg_i;
                        r_error <= 2'd0;
                        r_valid <= 1'b0;
                        r_word  <= 4'h0;
                        r_dig   <= 3'h0;
                        r_poll  <= 16'h0;
                        r_busy  <= 1'b1;
                        r_state <= S_RD_ID;
                    end
                end
                S_FIN: begin
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (!r_cyc) begin
                        // The cycle after a completion always has cyc low, which gives the idle gap.
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_sel <= 4'hF;
                        r_we  <= w_we;
                        r_adr <= w_adr;
                        r_dat <= w_dat;
                        r_tmo <= 8'h0;
                    end else if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= 4'h0;
                        r_adr <= 32'h0;
                        r_dat <= 32'h0;
                        case (r_state)
                            S_RD_ID: begin
                                if (wbm_dat_i == SHA1_ID) begin
                                    r_state <= S_WR_ON;
                                end else begin
                                    r_error <= 2'd1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end
                            S_WR_ON: r_state <= S_WR_MSG;
                            S_WR_MSG: begin
                                if (r_word == 4'd15) r_state <= S_POLL;
                                else                 r_word  <= r_word + 4'd1;
                            end
                            S_POLL: begin
                                if (wbm_dat_i[3]) begin
                                    r_state <= S_RD_DIG;
                                end else if (w_poll_next == L_POLL) begin
                                    r_error <= 2'd3;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_poll <= w_poll_next;
                                end
                            end
                            S_RD_DIG: begin
                                r_digest[{r_dig, 5'b0} +: 32] <= wbm_dat_i;
                                if (r_dig == 3'd4) r_state <= S_FIN;
                                else               r_dig   <= r_dig + 3'd1;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else if (r_tmo == L_TMO) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'h0;
                        r_adr   <= 32'h0;
                        r_dat   <= 32'h0;
                        r_error <= 2'd2;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign digest_o     = r_digest;
    assign digest_valid = r_valid;
    assign error        = r_error;
    assign wbm_cyc_o    = r_cyc;
    assign wbm_stb_o    = r_stb;
    assign wbm_we_o     = r_we;
    assign wbm_sel_o    = r_sel;
    assign wbm_adr_o    = r_adr;
    assign wbm_dat_o    = r_dat;

endmodule

// File: tb/tb_sha1_wb_master.sv
// Bench for sha1_wb_master. It contains a SHA1 peripheral responder model, a
// queue-based scoreboard of expected bus transfers and run results, and a
// protocol checker that examines every strobe.
module tb_sha1_wb_master;

    localparam logic [31:0] BASE    = 32'h30000024;
    localparam logic [31:0] A_ID    = BASE + 32'h4;
    localparam logic [31:0] A_MSG   = BASE + 32'h8;
    localparam logic [31:0] A_OPS   = BASE + 32'hC;
    localparam logic [31:0] A_DIG   = BASE + 32'h14;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    typedef struct packed {
        logic [1:0]   err;
        logic         valid;
        logic         chk_dig;
        logic [159:0] dig;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] msg = '0;
    logic         busy;
    logic [159:0] digest;
    logic         dvalid;
    logic [1:0]   err;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_o;
    logic         ack = 1'b0;
    logic [31:0]  dat_i = '0;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;

    xfer_t exp_q[$];
    res_t  res_q[$];

    // Responder model state
    bit          m_bad_id;
    int          m_done_at;
    int          m_hold_idx;
    int          m_poll_cnt, m_dig_cnt, m_msg_cnt;
    bit          pend = 1'b0;
    logic [31:0] pend_dat;
    bit          prev_stb = 1'b0, prev_cyc = 1'b0;
    int          hold_cyc = 0;

    logic [159:0] exp_dig;

    sha1_wb_master #(
        .BASE_ADDRESS(BASE),
        .ACK_TIMEOUT (16),
        .POLL_MAX    (4)
    ) dut (
        .wb_clk_i    (clk),
        .reset       (rst),
        .start       (start),
        .msg_i       (msg),
        .busy        (busy),
        .digest_o    (digest),
        .digest_valid(dvalid),
        .error       (err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Peripheral responder: a registered ack one cycle after the strobe, plus per-strobe checks.
    always @(negedge clk) begin
        xfer_t e;
        ack = 1'b0;
        if (pend) begin
            ack   = 1'b1;
            dat_i = pend_dat;
            pend  = 1'b0;
        end
        if (cyc && stb) begin
            chk("stb_one_cycle", 160'(prev_stb), 160'd0);
            chk("idle_gap", 160'(prev_cyc), 160'd0);
            chk("sel", 160'(sel), 160'hF);
            if (exp_q.size() == 0) begin
                chk("extra_xfer", 160'(exp_q.size()), 160'd1);
            end else begin
                e = exp_q.pop_front();
                chk("xfer", 160'({we, adr, (we ? dat_o : 32'h0)}), 160'(e));
            end
            pend     = 1'b1;
            pend_dat = 32'hDEADBEEF;
            if (!we && adr == A_ID) begin
                pend_dat = m_bad_id ? 32'hF00DF00D : 32'h53484131;
            end else if (!we && adr == A_OPS) begin
                m_poll_cnt++;
                pend_dat = (m_done_at != 0 && m_poll_cnt >= m_done_at) ? 32'h8 : 32'h0;
            end else if (!we && adr == A_DIG) begin
                m_dig_cnt++;
                pend_dat = 32'h11111111 * m_dig_cnt;
            end else if (we && adr == A_MSG) begin
                if (m_msg_cnt == m_hold_idx) begin
                    pend     = 1'b0;
                    hold_cyc = cyc_n;
                end
                m_msg_cnt++;
            end
        end
        prev_stb = stb;
        prev_cyc = cyc;
    end

    task automatic model_cfg(input bit bad, input int done_at, input int hold_idx);
        m_bad_id   = bad;
        m_done_at  = done_at;
        m_hold_idx = hold_idx;
        m_poll_cnt = 0;
        m_dig_cnt  = 0;
        m_msg_cnt  = 0;
    endtask

    task automatic push_seq(input logic [511:0] m, input bit on, input int n_msg,
                            input int n_poll, input int n_dig);
        exp_q.push_back('{we: 1'b0, adr: A_ID, dat: 32'h0});
        if (on) exp_q.push_back('{we: 1'b1, adr: A_OPS, dat: 32'h1});
        for (int k = 0; k < n_msg; k++) exp_q.push_back('{we: 1'b1, adr: A_MSG, dat: m[32*k +: 32]});
        for (int k = 0; k < n_poll; k++) exp_q.push_back('{we: 1'b0, adr: A_OPS, dat: 32'h0});
        for (int k = 0; k < n_dig; k++) exp_q.push_back('{we: 1'b0, adr: A_DIG, dat: 32'h0});
    endtask

    task automatic run(input logic [511:0] m, input bit poke, output int end_cyc);
        bit   done;
        res_t r;
        @(negedge clk);
        msg   = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        msg   = ~m;
        chk("busy_set", 160'(busy), 160'd1);
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start = (poke && i == 20);
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        end_cyc = cyc_n;
        if (!done) chk("busy_timeout", 160'(busy), 160'd0);
        r = res_q.pop_front();
        chk("error", 160'(err), 160'(r.err));
        chk("digest_valid", 160'(dvalid), 160'(r.valid));
        if (r.chk_dig) chk("digest", digest, r.dig);
        chk("cyc_idle", 160'(cyc), 160'd0);
        chk("xfers_left", 160'(exp_q.size()), 160'd0);
        exp_q.delete();
    endtask

    function automatic logic [511:0] mk_msg(input logic [31:0] x);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'(k) ^ x;
        return v;
    endfunction

    initial begin
        int t_end;
        logic [511:0] m;
        bit found;
        for (int k = 0; k < 5; k++) exp_dig[32*k +: 32] = 32'h11111111 * (k + 1);

        repeat (3) @(negedge clk);
        chk("reset_outs", 160'({busy, dvalid, err, cyc, stb, we, sel, adr, dat_o}), 160'd0);
        chk("reset_digest", digest, 160'd0);
        rst = 1'b0;

        // Happy path, word k = k
        m = mk_msg(32'h0);
        model_cfg(0, 3, -1);
        push_seq(m, 1, 16, 3, 5);
        res_q.push_back('{err: 2'd0, valid: 1'b1, chk_dig: 1'b1, dig: exp_dig});
        run(m, 0, t_end);

        // Second start pulse while busy must not add transfers
        m = mk_msg(32'hA5A5A5A5);
        model_cfg(0, 3, -1);
        push_seq(m, 1, 16, 3, 5);
        res_q.push_back('{err: 2'd0, valid: 1'b1, chk_dig: 1'b1, dig: exp_dig});
        run(m, 1, t_end);

        // Bad ID
        model_cfg(1, 3, -1);
        push_seq(m, 0, 0, 0, 0);
        res_q.push_back('{err: 2'd1, valid: 1'b0, chk_dig: 1'b0, dig: '0});
        run(m, 0, t_end);

        // Ack withheld on the 4th message write
        model_cfg(0, 3, 3);
        push_seq(m, 1, 4, 0, 0);
        res_q.push_back('{err: 2'd2, valid: 1'b0, chk_dig: 1'b0, dig: '0});
        run(m, 0, t_end);
        chk("timeout_latency", 160'(t_end - hold_cyc), 160'd17);

        // DONE never set, POLL_MAX = 4
        model_cfg(0, 0, -1);
        push_seq(m, 1, 16, 4, 0);
        res_q.push_back('{err: 2'd3, valid: 1'b0, chk_dig: 1'b0, dig: '0});
        run(m, 0, t_end);
        chk("poll_reads", 160'(m_poll_cnt), 160'd4);

        // Reset asserted while word 7 is being written
        m = mk_msg(32'h0);
        model_cfg(0, 3, -1);
        push_seq(m, 1, 16, 3, 5);
        @(negedge clk);
        msg   = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (stb && we && adr == A_MSG && dat_o == 32'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("word7_seen", 160'(found), 160'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", 160'({busy, dvalid, err, cyc, stb, we, sel, adr, dat_o}), 160'd0);
        chk("rst_mid_digest", digest, 160'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_cfg(0, 3, -1);
        push_seq(m, 1, 16, 3, 5);
        res_q.push_back('{err: 2'd0, valid: 1'b1, chk_dig: 1'b1, dig: exp_dig});
        run(m, 0, t_end);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
